// File: rtl/reg_writeback.sv
// reg_writeback: merges load and ALU results into a single register-file
// write port. Results that cannot be written in the current cycle wait in a
// 2-entry pending FIFO. Writes leave in acceptance order: FIFO entries first,
// then the load, then the ALU result.
//
// Optional feature (macro WB_FWD_EN): adds lookup_addr/fwd_hit/fwd_data so
// consumers can read the youngest pending value for a register before it
// reaches the register file. Without the macro, those ports and the lookup
// logic are not built.
module reg_writeback #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8,
    localparam int AW    = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_addr,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
`ifdef WB_FWD_EN
    input  logic [AW-1:0]    lookup_addr,
    output logic             fwd_hit,
    output logic [WIDTH-1:0] fwd_data,
`endif
    output logic             stall,
    output logic             RegWrite,
    output logic [AW-1:0]    write_address,
    output logic [WIDTH-1:0] write_data
);

    // Pending FIFO: entry 0 is always the oldest.
    logic [AW-1:0]    fifo_addr_r [0:1];
    logic [WIDTH-1:0] fifo_data_r [0:1];
    logic [1:0]       count_r;

    // Output register driving the register-file write port.
    logic             reg_write_r;
    logic [AW-1:0]    wr_addr_r;
    logic [WIDTH-1:0] wr_data_r;

    // Ordered candidate list for this cycle (at most 3 entries can exist).
    logic [AW-1:0]    cand_addr_s [0:2];
    logic [WIDTH-1:0] cand_data_s [0:2];
    logic [1:0]       n_cand_s;

    logic             stall_s;
    logic             ld_acc_s;
    logic             alu_acc_s;

    // A full FIFO refuses both producers; new inputs are dropped, not queued.
    assign stall_s   = (count_r == 2'd2);
    assign ld_acc_s  = ld_valid  & ~stall_s;
    assign alu_acc_s = alu_valid & ~stall_s;

    // Build the ordered candidate list: FIFO oldest first, then load, then ALU.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cand_addr_s[i] = '0;
            cand_data_s[i] = '0;
        end
        n_cand_s = 2'd0;
        case (count_r)
            2'd0: begin
                if (ld_acc_s) begin
                    cand_addr_s[0] = ld_addr;
                    cand_data_s[0] = ld_data;
                    cand_addr_s[1] = alu_addr;
                    cand_data_s[1] = alu_data;
                    n_cand_s       = 2'd1 + {1'b0, alu_acc_s};
                end else begin
                    cand_addr_s[0] = alu_addr;
                    cand_data_s[0] = alu_data;
                    n_cand_s       = {1'b0, alu_acc_s};
                end
            end
            2'd1: begin
                cand_addr_s[0] = fifo_addr_r[0];
                cand_data_s[0] = fifo_data_r[0];
                if (ld_acc_s) begin
                    cand_addr_s[1] = ld_addr;
                    cand_data_s[1] = ld_data;
                    cand_addr_s[2] = alu_addr;
                    cand_data_s[2] = alu_data;
                    n_cand_s       = 2'd2 + {1'b0, alu_acc_s};
                end else begin
                    cand_addr_s[1] = alu_addr;
                    cand_data_s[1] = alu_data;
                    n_cand_s       = 2'd1 + {1'b0, alu_acc_s};
                end
            end
            2'd2: begin
                cand_addr_s[0] = fifo_addr_r[0];
                cand_data_s[0] = fifo_data_r[0];
                cand_addr_s[1] = fifo_addr_r[1];
                cand_data_s[1] = fifo_data_r[1];
                n_cand_s       = 2'd2;
            end
            default: begin
                n_cand_s = 2'd0;
            end
        endcase
    end

    // Emit the first candidate and keep the rest (in order) as pending entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r    <= 1'b0;
            wr_addr_r      <= '0;
            wr_data_r      <= '0;
            count_r        <= 2'd0;
            fifo_addr_r[0] <= '0;
            fifo_data_r[0] <= '0;
            fifo_addr_r[1] <= '0;
            fifo_data_r[1] <= '0;
        end else begin
            if (n_cand_s != 2'd0) begin
                reg_write_r <= 1'b1;
                wr_addr_r   <= cand_addr_s[0];
                wr_data_r   <= cand_data_s[0];
                count_r     <= n_cand_s - 2'd1;
            end else begin
                reg_write_r <= 1'b0;
                count_r     <= 2'd0;
            end
            // Slots beyond the new count carry don't-care contents.
            fifo_addr_r[0] <= cand_addr_s[1];
            fifo_data_r[0] <= cand_data_s[1];
            fifo_addr_r[1] <= cand_addr_s[2];
            fifo_data_r[1] <= cand_data_s[2];
        end
    end

    assign stall         = stall_s;
    assign RegWrite      = reg_write_r;
    assign write_address = wr_addr_r;
    assign write_data    = wr_data_r;

`ifdef WB_FWD_EN
    // Youngest-match lookup: FIFO tail, then FIFO head, then the output register.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if ((count_r == 2'd2) && (fifo_addr_r[1] == lookup_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_data_r[1];
        end else if ((count_r != 2'd0) && (fifo_addr_r[0] == lookup_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_data_r[0];
        end else if (reg_write_r && (wr_addr_r == lookup_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data_r;
        end else begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a table of hand-derived vectors,
// a randomised phase checked against a scoreboard queue of pending writes,
// and hand-written reset / forwarding sequences.
module tb_reg_writeback;

    localparam int WIDTH  = 16;
    localparam int N_REGS = 8;
    localparam int AW     = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alu_valid = 1'b0;
    logic [AW-1:0]    alu_addr = '0;
    logic [WIDTH-1:0] alu_data = '0;
    logic             ld_valid = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [WIDTH-1:0] ld_data = '0;
    logic             stall;
    logic             RegWrite;
    logic [AW-1:0]    write_address;
    logic [WIDTH-1:0] write_data;
`ifdef WB_FWD_EN
    logic [AW-1:0]    lookup_addr = '0;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
`endif

    reg_writeback #(.WIDTH(WIDTH), .N_REGS(N_REGS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
`ifdef WB_FWD_EN
        .lookup_addr   (lookup_addr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
`endif
        .stall         (stall),
        .RegWrite      (RegWrite),
        .write_address (write_address),
        .write_data    (write_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        lv;
        logic [2:0]  la;
        logic [15:0] ldd;
        logic        av;
        logic [2:0]  aa;
        logic [15:0] ad;
        logic        st;   // expected stall before the edge
        logic        rw;   // expected outputs after the edge
        logic [2:0]  wa;
        logic [15:0] wd;
    } vec_t;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    vec_t vecs [14];
    wr_t  sb_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [2:0] la, input logic [15:0] ldd,
                         input logic av, input logic [2:0] aa, input logic [15:0] ad);
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ldd;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
    endtask

    // One scoreboarded cycle: accepted inputs are queued, each edge pops one.
    task automatic sb_cycle(input logic lv, input logic [2:0] la, input logic [15:0] ldd,
                            input logic av, input logic [2:0] aa, input logic [15:0] ad);
        wr_t e;
        bit  full;
        @(negedge clk);
        full = (sb_q.size() == 2);
        chk("sb_stall", stall, full);
        drive(lv, la, ldd, av, aa, ad);
        if (!full) begin
            if (lv) sb_q.push_back('{a: la, d: ldd});
            if (av) sb_q.push_back('{a: aa, d: ad});
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_regwrite", RegWrite, 1);
            chk("sb_addr", write_address, e.a);
            chk("sb_data", write_data, e.d);
        end else begin
            chk("sb_idle", RegWrite, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          lv    la    ldd        av    aa    ad         st    rw    wa    wd
        vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h1234};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 16'h1234};
        vecs[2]  = '{1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b1, 3'd2, 16'hAAAA};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'h5555};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd5, 16'h5555};
        vecs[5]  = '{1'b1, 3'd1, 16'h0101, 1'b1, 3'd6, 16'h0606, 1'b0, 1'b1, 3'd1, 16'h0101};
        vecs[6]  = '{1'b1, 3'd7, 16'h0707, 1'b1, 3'd0, 16'h0A0A, 1'b0, 1'b1, 3'd6, 16'h0606};
        vecs[7]  = '{1'b1, 3'd3, 16'hDEAD, 1'b1, 3'd4, 16'hBEEF, 1'b1, 1'b1, 3'd7, 16'h0707};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h0A0A};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0A0A};
        vecs[10] = '{1'b1, 3'd4, 16'h1111, 1'b1, 3'd4, 16'h2222, 1'b0, 1'b1, 3'd4, 16'h1111};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h2222};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h5A5A, 1'b0, 1'b1, 3'd5, 16'h5A5A};
        vecs[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd5, 16'h5A5A};

        // Reset state while rst_n is low.
        #12;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_addr", write_address, 0);
        chk("rst_data", write_data, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].st);
            drive(vecs[i].lv, vecs[i].la, vecs[i].ldd, vecs[i].av, vecs[i].aa, vecs[i].ad);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_regwrite", i), RegWrite, vecs[i].rw);
            chk($sformatf("vec%0d_addr", i), write_address, vecs[i].wa);
            chk($sformatf("vec%0d_data", i), write_data, vecs[i].wd);
        end

        // Randomised traffic against the scoreboard, then drain.
        for (int c = 0; c < 300; c++) begin
            sb_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
        end
        for (int c = 0; c < 4; c++) begin
            sb_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        end

        // Reset with two writes pending: outputs clear at once, nothing replays.
        sb_cycle(1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'h0002);
        sb_cycle(1'b1, 3'd3, 16'h0003, 1'b1, 3'd4, 16'h0004);
        @(negedge clk);
        chk("pre_rst_stall", stall, 1);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("arst_regwrite", RegWrite, 0);
        chk("arst_addr", write_address, 0);
        chk("arst_data", write_data, 0);
        chk("arst_stall", stall, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        chk("arst_hold_regwrite", RegWrite, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sb_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        end
        sb_cycle(1'b1, 3'd2, 16'h0BAD, 1'b0, 3'd0, 16'h0000);
        sb_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);

`ifdef WB_FWD_EN
        // Pending r6=0x00FF is younger than the output register r6=0x0001.
        sb_cycle(1'b1, 3'd6, 16'h0001, 1'b1, 3'd6, 16'h00FF);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        lookup_addr = 3'd6;
        #1;
        chk("fwd_hit6", fwd_hit, 1);
        chk("fwd_data6", fwd_data, 16'h00FF);
        lookup_addr = 3'd7;
        #1;
        chk("fwd_hit7", fwd_hit, 0);
        chk("fwd_data7", fwd_data, 0);
        sb_cycle(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
